// File: rtl/id_ex_stage.sv
// Instruction decode and ID/EX pipeline register with load-use hazard
// detection and branch flush for the five-stage MIPS core.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [5:0]  ex_aluop,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_movz,
  output logic        illegal_seen
);

  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_MOVZ = 6'h0A;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_SLT  = 6'h2A;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;

  assign op     = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];
  assign shamt  = id_instr[10:6];
  assign funct  = id_instr[5:0];
  assign imm    = id_instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign imm_zx = {16'h0000, imm};

  logic [5:0]  d_aluop;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic [4:0]  d_dst;
  logic        d_reg_write;
  logic        d_mem_read;
  logic        d_mem_write;
  logic        d_branch;
  logic        d_movz;
  logic        d_legal;
  logic        uses_rs;
  logic        uses_rt;

  always_comb begin
    d_aluop     = ALU_ADD;
    d_a         = id_rs_data;
    d_b         = id_rt_data;
    d_dst       = '0;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_movz      = 1'b0;
    d_legal     = 1'b1;
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    unique case (op)
      6'h00: begin
        d_dst       = rd;
        d_reg_write = 1'b1;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        case (funct)
          6'h20: d_aluop = ALU_ADD;
          6'h22: d_aluop = ALU_SUB;
          6'h24: d_aluop = ALU_AND;
          6'h25: d_aluop = ALU_OR;
          6'h26: d_aluop = ALU_XOR;
          6'h2A: d_aluop = ALU_SLT;
          6'h0A: begin
            d_aluop = ALU_MOVZ;
            d_movz  = 1'b1;
          end
          6'h00: begin
            d_aluop = ALU_SLL;
            d_a     = {27'b0, shamt};
            uses_rs = 1'b0;
          end
          default: d_legal = 1'b0;
        endcase
      end
      6'h08: begin
        d_b = imm_sx; d_dst = rt; d_reg_write = 1'b1; uses_rs = 1'b1;
      end
      6'h0D: begin
        d_aluop = ALU_OR; d_b = imm_zx; d_dst = rt; d_reg_write = 1'b1; uses_rs = 1'b1;
      end
      6'h23: begin
        d_b = imm_sx; d_dst = rt; d_reg_write = 1'b1; d_mem_read = 1'b1; uses_rs = 1'b1;
      end
      6'h2B: begin
        d_b = imm_sx; d_mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      6'h04: begin
        d_aluop = ALU_SUB; d_branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    if (d_dst == 5'd0) d_reg_write = 1'b0;
    // Undecodable words carry no controls and no register reads.
    if (!d_legal) begin
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_branch    = 1'b0;
      d_movz      = 1'b0;
      uses_rs     = 1'b0;
      uses_rt     = 1'b0;
    end
  end

  logic hazard;
  logic load;

  assign hazard = ex_valid & ex_mem_read & (ex_dst != 5'd0) & id_valid &
                  ((uses_rs & (ex_dst == rs)) | (uses_rt & (ex_dst == rt)));
  assign id_ready = ~hazard;
  assign load     = ~flush & ~hazard & id_valid & d_legal;

  // Datapath fields load every cycle; only ex_valid and controls are gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_aluop      <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dst        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_movz       <= 1'b0;
      illegal_seen  <= 1'b0;
    end else begin
      ex_valid      <= load;
      ex_aluop      <= d_aluop;
      ex_a          <= d_a;
      ex_b          <= d_b;
      ex_store_data <= id_rt_data;
      ex_rs         <= rs;
      ex_rt         <= rt;
      ex_dst        <= d_dst;
      ex_reg_write  <= load & d_reg_write;
      ex_mem_read   <= load & d_mem_read;
      ex_mem_write  <= load & d_mem_write;
      ex_branch     <= load & d_branch;
      ex_movz       <= load & d_movz;
      if (id_valid & ~flush & ~hazard & ~d_legal) illegal_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: decode forms, load-use stall,
// flush, illegal tracking and asynchronous reset.
module tb_id_ex_stage;

  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_MOVZ = 6'h0A;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_SLT  = 6'h2A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        flush;
  logic        id_ready;
  logic        ex_valid;
  logic [5:0]  ex_aluop;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_movz;
  logic        illegal_seen;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_movz(ex_movz),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic rw, input logic mr,
                         input logic mw, input logic br, input logic mz);
    check({tag, ".valid"}, 32'(ex_valid), 32'(v));
    check({tag, ".rw"},    32'(ex_reg_write), 32'(rw));
    check({tag, ".mr"},    32'(ex_mem_read), 32'(mr));
    check({tag, ".mw"},    32'(ex_mem_write), 32'(mw));
    check({tag, ".br"},    32'(ex_branch), 32'(br));
    check({tag, ".mz"},    32'(ex_movz), 32'(mz));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        rw, mr, mw, br, mz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h00221820, ALU_ADD,  32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[1]  = '{32'h00221822, ALU_SUB,  32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[2]  = '{32'h00221824, ALU_AND,  32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[3]  = '{32'h00221825, ALU_OR,   32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[4]  = '{32'h00221826, ALU_XOR,  32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[5]  = '{32'h0022182A, ALU_SLT,  32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 0};
    vecs[6]  = '{32'h0022180A, ALU_MOVZ, 32'h5, 32'hFFFFFFFE, 5'd3, 1, 0, 0, 0, 1};
    vecs[7]  = '{32'h20248001, ALU_ADD,  32'h5, 32'hFFFF8001, 5'd4, 1, 0, 0, 0, 0};
    vecs[8]  = '{32'h34248001, ALU_OR,   32'h5, 32'h00008001, 5'd4, 1, 0, 0, 0, 0};
    vecs[9]  = '{32'h8C248001, ALU_ADD,  32'h5, 32'hFFFF8001, 5'd4, 1, 1, 0, 0, 0};
    vecs[10] = '{32'hAC228001, ALU_ADD,  32'h5, 32'hFFFF8001, 5'd0, 0, 0, 1, 0, 0};
    vecs[11] = '{32'h10228001, ALU_SUB,  32'h5, 32'hFFFFFFFE, 5'd0, 0, 0, 0, 1, 0};
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; flush = 1'b0;
    id_rs_data = 32'h0000_0005; id_rt_data = 32'hFFFF_FFFE;
    #12;
    chk_ctl("reset", 0, 0, 0, 0, 0, 0);
    check("reset.aluop", 32'(ex_aluop), 32'h0);
    check("reset.a", ex_a, 32'h0);
    check("reset.ill", 32'(illegal_seen), 32'h0);
    check("reset.ready", 32'(id_ready), 32'h1);
    @(negedge clk); rst_n = 1'b1;

    id_valid = 1'b1;
    foreach (vecs[i]) begin
      id_instr = vecs[i].instr;
      step();
      check($sformatf("dec%0d.aluop", i), 32'(ex_aluop), 32'(vecs[i].aluop));
      check($sformatf("dec%0d.a", i), ex_a, vecs[i].a);
      check($sformatf("dec%0d.b", i), ex_b, vecs[i].b);
      check($sformatf("dec%0d.dst", i), 32'(ex_dst), 32'(vecs[i].dst));
      check($sformatf("dec%0d.sd", i), ex_store_data, 32'hFFFFFFFE);
      chk_ctl($sformatf("dec%0d", i), 1, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].mz);
    end

    // sll $3,$2,4
    id_instr = 32'h00021900;
    step();
    check("sll.aluop", 32'(ex_aluop), 32'(ALU_SLL));
    check("sll.a", ex_a, 32'h4);
    check("sll.b", ex_b, 32'hFFFFFFFE);
    check("sll.dst", 32'(ex_dst), 32'd3);
    check("sll.rw", 32'(ex_reg_write), 32'h1);

    // lw $5 then add $6,$5,$1: one stall
    id_instr = 32'h8C250000;
    step();
    id_instr = 32'h00A13020;
    #1 check("lu.ready0", 32'(id_ready), 32'h0);
    step();
    chk_ctl("lu.bubble", 0, 0, 0, 0, 0, 0);
    check("lu.ready1", 32'(id_ready), 32'h1);
    step();
    check("lu.add.valid", 32'(ex_valid), 32'h1);
    check("lu.add.dst", 32'(ex_dst), 32'd6);
    check("lu.add.aluop", 32'(ex_aluop), 32'(ALU_ADD));

    // lw $5 then addi $6,$7,1: no stall
    id_instr = 32'h8C250000;
    step();
    id_instr = 32'h20E60001;
    #1 check("nolu.ready", 32'(id_ready), 32'h1);
    step();
    check("nolu.valid", 32'(ex_valid), 32'h1);
    check("nolu.dst", 32'(ex_dst), 32'd6);
    check("nolu.b", ex_b, 32'h1);

    // flush on a plain add
    id_instr = 32'h00221820; flush = 1'b1;
    step();
    flush = 1'b0;
    chk_ctl("flush", 0, 0, 0, 0, 0, 0);

    // flush coinciding with a load-use hazard
    id_instr = 32'h8C250000;
    step();
    id_instr = 32'h00A13020; flush = 1'b1;
    #1 check("flhz.ready0", 32'(id_ready), 32'h0);
    step();
    flush = 1'b0;
    chk_ctl("flhz.bubble", 0, 0, 0, 0, 0, 0);
    check("flhz.ready1", 32'(id_ready), 32'h1);
    step();
    check("flhz.add.valid", 32'(ex_valid), 32'h1);
    check("flhz.add.dst", 32'(ex_dst), 32'd6);

    // illegal op 0x3F
    id_instr = 32'hFC000000;
    step();
    chk_ctl("ill", 0, 0, 0, 0, 0, 0);
    check("ill.seen", 32'(illegal_seen), 32'h1);
    id_instr = 32'h00221820;
    step();
    check("ill.sticky.valid", 32'(ex_valid), 32'h1);
    check("ill.sticky", 32'(illegal_seen), 32'h1);

    // async reset between edges while ex_valid=1
    #3 rst_n = 1'b0;
    #1;
    chk_ctl("areset", 0, 0, 0, 0, 0, 0);
    check("areset.a", ex_a, 32'h0);
    check("areset.dst", 32'(ex_dst), 32'h0);
    check("areset.ill", 32'(illegal_seen), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("resume.valid", 32'(ex_valid), 32'h1);
    check("resume.rw", 32'(ex_reg_write), 32'h1);
    check("resume.a", ex_a, 32'h5);

    // illegal under flush leaves illegal_seen clear
    id_instr = 32'hFC000000; flush = 1'b1;
    step();
    flush = 1'b0;
    check("illfl.seen", 32'(illegal_seen), 32'h0);
    check("illfl.valid", 32'(ex_valid), 32'h0);

    // id_valid low: bubble
    id_valid = 1'b0; id_instr = 32'h00221820;
    step();
    chk_ctl("novalid", 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
